// File: rtl/fifo_wr_arbiter.sv
// Round-robin burst arbiter for four byte-wide requesters sharing one FIFO write port.
// Define FIFO_WR_ARBITER_STATS_EN to add the saturating words_written counter.
module fifo_wr_arbiter #(
  parameter int BURST_LEN = 4
) (
  input  logic        clock,
  input  logic        rst,
  input  logic [3:0]  req,
  input  logic [31:0] req_data,
  input  logic        fifo_full,
  output logic [3:0]  gnt,
  output logic [3:0]  wr_ack,
  output logic        fifo_wr,
  output logic [7:0]  fifo_data_in
`ifdef FIFO_WR_ARBITER_STATS_EN
  ,
  output logic [15:0] words_written
`endif
);

  localparam int DATA_W = 8;
  localparam int CNT_W  = (BURST_LEN > 1) ? $clog2(BURST_LEN) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(BURST_LEN - 1);

  typedef enum logic {IDLE, BURST} state_t;

  state_t           state, state_nxt;
  logic [1:0]       owner, owner_nxt;
  logic [1:0]       rr_ptr, rr_ptr_nxt;
  logic [CNT_W-1:0] cnt, cnt_nxt;
  logic [3:0]       gnt_nxt;
  logic [1:0]       pick;
  logic             pick_vld;
  logic             wr_en;
  logic             burst_done;

  // First requester at or after rr_ptr wins; scanning downward lets the nearest one overwrite.
  always_comb begin
    pick     = rr_ptr;
    pick_vld = 1'b0;
    for (int k = 3; k >= 0; k--) begin
      if (req[rr_ptr + 2'(k)]) begin
        pick     = rr_ptr + 2'(k);
        pick_vld = 1'b1;
      end
    end
  end

  assign wr_en      = (state == BURST) && req[owner] && !fifo_full;
  assign burst_done = (state == BURST) && ((wr_en && (cnt == CNT_LAST)) || !req[owner]);

  always_ff @(posedge clock) begin
    if (rst) begin
      state  <= IDLE;
      owner  <= 2'd0;
      rr_ptr <= 2'd0;
      cnt    <= '0;
      gnt    <= 4'd0;
    end else begin
      state  <= state_nxt;
      owner  <= owner_nxt;
      rr_ptr <= rr_ptr_nxt;
      cnt    <= cnt_nxt;
      gnt    <= gnt_nxt;
    end
  end

  always_comb begin
    state_nxt  = state;
    owner_nxt  = owner;
    rr_ptr_nxt = rr_ptr;
    cnt_nxt    = cnt;
    gnt_nxt    = gnt;
    if (state == IDLE) begin
      if (pick_vld && !fifo_full) begin
        state_nxt = BURST;
        owner_nxt = pick;
        gnt_nxt   = 4'b0001 << pick;
        cnt_nxt   = '0;
      end
    end else begin
      // A full FIFO stalls the burst: counter holds and the grant is kept.
      if (burst_done) begin
        state_nxt  = IDLE;
        rr_ptr_nxt = owner + 2'd1;
        gnt_nxt    = 4'd0;
        cnt_nxt    = '0;
      end else if (wr_en) begin
        cnt_nxt = cnt + CNT_W'(1);
      end
    end
  end

  always_comb begin
    fifo_wr      = wr_en;
    fifo_data_in = wr_en ? req_data[{owner, 3'b000} +: DATA_W] : '0;
    wr_ack       = gnt & {4{wr_en}};
  end

`ifdef FIFO_WR_ARBITER_STATS_EN
  function automatic logic [15:0] sat_inc16(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

  always_ff @(posedge clock) begin
    if (rst) begin
      words_written <= 16'd0;
    end else if (wr_en) begin
      words_written <= sat_inc16(words_written);
    end
  end
`endif

endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// Directed bench for fifo_wr_arbiter: vector table plus burst, rotation, stall and stats sequences.
module tb_fifo_wr_arbiter;

  logic        clock;
  logic        rst;
  logic [3:0]  req;
  logic [31:0] req_data;
  logic        fifo_full;
  logic [3:0]  gnt;
  logic [3:0]  wr_ack;
  logic        fifo_wr;
  logic [7:0]  fifo_data_in;
`ifdef FIFO_WR_ARBITER_STATS_EN
  logic [15:0] words_written;
`endif

  int tests  = 0;
  int failed = 0;

  fifo_wr_arbiter #(.BURST_LEN(4)) dut (
    .clock        (clock),
    .rst          (rst),
    .req          (req),
    .req_data     (req_data),
    .fifo_full    (fifo_full),
    .gnt          (gnt),
    .wr_ack       (wr_ack),
    .fifo_wr      (fifo_wr),
    .fifo_data_in (fifo_data_in)
`ifdef FIFO_WR_ARBITER_STATS_EN
    ,
    .words_written(words_written)
`endif
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  typedef struct {
    logic       rst;
    logic [3:0] req;
    logic       full;
    logic       chk;
    logic [3:0] gnt;
    logic       wr;
    logic [7:0] din;
    logic [3:0] ack;
  } vec_t;

  localparam logic [31:0] DATA_ALL = 32'hD3C2B1A0;

  vec_t tbl[20];

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    if (got !== exp) begin
      failed++;
      $display("FAIL %s: got %h, expected %h", name, got, exp);
    end
  endtask

  task automatic next_cycle();
    @(posedge clock);
    #1;
  endtask

  task automatic do_reset();
    rst       = 1'b1;
    req       = 4'd0;
    fifo_full = 1'b0;
    req_data  = DATA_ALL;
    repeat (2) @(posedge clock);
    #1;
    rst = 1'b0;
  endtask

  function automatic int enc(input logic [3:0] g);
    for (int i = 0; i < 4; i++) if (g[i]) return i;
    return 7;
  endfunction

  logic [7:0] wval[8];
  int         wcyc[8];
  int         nw;
  int         idx;
  int         bad_oh;
  int         b_own[24];
  logic [7:0] b_din[24];
  int         b_cyc[24];
  int         nb;

  initial begin
    // rst, req, full, chk, gnt, wr, din, ack
    tbl[0]  = '{1'b1, 4'b0000, 1'b0, 1'b0, 4'b0000, 1'b0, 8'h00, 4'b0000};
    tbl[1]  = '{1'b1, 4'b1111, 1'b0, 1'b1, 4'b0000, 1'b0, 8'h00, 4'b0000};
    tbl[2]  = '{1'b0, 4'b0000, 1'b0, 1'b1, 4'b0000, 1'b0, 8'h00, 4'b0000};
    tbl[3]  = '{1'b0, 4'b0001, 1'b1, 1'b1, 4'b0000, 1'b0, 8'h00, 4'b0000};
    tbl[4]  = '{1'b0, 4'b0001, 1'b0, 1'b1, 4'b0000, 1'b0, 8'h00, 4'b0000};
    tbl[5]  = '{1'b0, 4'b0001, 1'b0, 1'b1, 4'b0001, 1'b1, 8'hA0, 4'b0001};
    tbl[6]  = '{1'b0, 4'b0001, 1'b0, 1'b1, 4'b0001, 1'b1, 8'hA0, 4'b0001};
    tbl[7]  = '{1'b0, 4'b0001, 1'b1, 1'b1, 4'b0001, 1'b0, 8'h00, 4'b0000};
    tbl[8]  = '{1'b0, 4'b0011, 1'b0, 1'b1, 4'b0001, 1'b1, 8'hA0, 4'b0001};
    tbl[9]  = '{1'b0, 4'b0011, 1'b0, 1'b1, 4'b0001, 1'b1, 8'hA0, 4'b0001};
    tbl[10] = '{1'b0, 4'b0011, 1'b0, 1'b1, 4'b0000, 1'b0, 8'h00, 4'b0000};
    tbl[11] = '{1'b0, 4'b0011, 1'b0, 1'b1, 4'b0010, 1'b1, 8'hB1, 4'b0010};
    tbl[12] = '{1'b0, 4'b0001, 1'b0, 1'b1, 4'b0010, 1'b0, 8'h00, 4'b0000};
    tbl[13] = '{1'b0, 4'b1001, 1'b0, 1'b1, 4'b0000, 1'b0, 8'h00, 4'b0000};
    tbl[14] = '{1'b0, 4'b1001, 1'b0, 1'b1, 4'b1000, 1'b1, 8'hD3, 4'b1000};
    tbl[15] = '{1'b1, 4'b1001, 1'b0, 1'b1, 4'b1000, 1'b1, 8'hD3, 4'b1000};
    tbl[16] = '{1'b0, 4'b1000, 1'b0, 1'b1, 4'b0000, 1'b0, 8'h00, 4'b0000};
    tbl[17] = '{1'b0, 4'b1000, 1'b0, 1'b1, 4'b1000, 1'b1, 8'hD3, 4'b1000};
    tbl[18] = '{1'b0, 4'b0000, 1'b0, 1'b1, 4'b1000, 1'b0, 8'h00, 4'b0000};
    tbl[19] = '{1'b0, 4'b0000, 1'b0, 1'b1, 4'b0000, 1'b0, 8'h00, 4'b0000};

    rst       = 1'b1;
    req       = 4'd0;
    fifo_full = 1'b0;
    req_data  = DATA_ALL;

    for (int i = 0; i < 20; i++) begin
      rst       = tbl[i].rst;
      req       = tbl[i].req;
      fifo_full = tbl[i].full;
      @(negedge clock);
      if (tbl[i].chk)
        check($sformatf("vec%0d gnt/wr/din/ack", i),
              {15'd0, gnt, fifo_wr, fifo_data_in, wr_ack},
              {15'd0, tbl[i].gnt, tbl[i].wr, tbl[i].din, tbl[i].ack});
      next_cycle();
    end

    // Lone requester with data stepping on wr_ack: 4 writes, one idle cycle, then 2 more.
    do_reset();
    nw  = 0;
    idx = 0;
    for (int k = 0; k < 8; k++) begin wval[k] = 8'h00; wcyc[k] = -1; end
    for (int c = 0; c < 40; c++) begin
      req      = (idx < 6) ? 4'b0001 : 4'b0000;
      req_data = {24'd0, 8'(8'hA0 + idx)};
      @(negedge clock);
      if (wr_ack[0] && nw < 8) begin
        wval[nw] = fifo_data_in;
        wcyc[nw] = c;
        nw++;
        idx++;
      end
      next_cycle();
    end
    check("lone_write_count", nw, 6);
    begin
      int exp_cyc[6] = '{1, 2, 3, 4, 6, 7};
      for (int k = 0; k < 6; k++) begin
        check($sformatf("lone_data%0d", k), {24'd0, wval[k]}, 32'hA0 + k);
        check($sformatf("lone_cycle%0d", k), wcyc[k], exp_cyc[k]);
      end
    end

    // All four requesting: rotation 0,1,2,3,0 with 4 writes each and one idle cycle between.
    do_reset();
    req    = 4'b1111;
    nb     = 0;
    bad_oh = 0;
    for (int c = 0; c < 30; c++) begin
      @(negedge clock);
      if (!$onehot0(gnt)) bad_oh++;
      if (fifo_wr && nb < 24) begin
        b_own[nb] = enc(gnt);
        b_din[nb] = fifo_data_in;
        b_cyc[nb] = c;
        nb++;
      end
      next_cycle();
    end
    check("rr_gnt_onehot_violations", bad_oh, 0);
    for (int k = 0; k < 20; k++) begin
      int eo;
      logic [7:0] ed;
      eo = (k / 4) % 4;
      ed = DATA_ALL[eo*8 +: 8];
      check($sformatf("rr_write%0d own/din/cyc", k),
            {4'(b_own[k]), b_din[k], 20'(b_cyc[k])},
            {4'(eo), ed, 20'(1 + k + k / 4)});
    end

    // Requester 2 stalled by fifo_full after 2 writes for 3 cycles, then finishes its burst.
    do_reset();
    req = 4'b0100;
    for (int c = 0; c < 9; c++) begin
      logic [16:0] exp;
      fifo_full = (c >= 3 && c <= 5);
      if (c == 1 || c == 2 || c == 6 || c == 7) exp = {4'b0100, 1'b1, 8'hC2, 4'b0100};
      else if (c >= 3 && c <= 5)                 exp = {4'b0100, 1'b0, 8'h00, 4'b0000};
      else                                       exp = 17'd0;
      @(negedge clock);
      check($sformatf("stall_cyc%0d gnt/wr/din/ack", c),
            {15'd0, gnt, fifo_wr, fifo_data_in, wr_ack}, {15'd0, exp});
      next_cycle();
    end
    fifo_full = 1'b0;
    req       = 4'b0000;

`ifdef FIFO_WR_ARBITER_STATS_EN
    do_reset();
    @(negedge clock);
    check("stats_after_reset", {16'd0, words_written}, 32'd0);
    next_cycle();
    idx = 0;
    for (int c = 0; c < 40; c++) begin
      req = (idx < 10) ? 4'b0001 : 4'b0000;
      @(negedge clock);
      if (wr_ack[0]) idx++;
      next_cycle();
    end
    check("stats_ten_writes", {16'd0, words_written}, 32'd10);
    rst = 1'b1;
    next_cycle();
    rst = 1'b0;
    @(negedge clock);
    check("stats_cleared", {16'd0, words_written}, 32'd0);
    next_cycle();
`endif

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
